hilo_acc_file: RTL and testbench

Parametrised successor of the single HI/LO register pair: a file of NUM_AC independent HI/LO accumulator pairs with direct-write, clear and multiply-accumulate (add/subtract) update modes. Every update flows through a fixed two-stage pipeline with internal forwarding, so back-to-back accumulates to the same pair run at one operation per cycle. Sits beside the multiplier/divider in EX/MEM. Supplies HI/LO read data and a per-pair pending flag to ID/EX for hazard detection.

---
 rtl/hilo_pkg.sv | 21 ++
 rtl/hilo_acc_alu.sv | 32 +++
 rtl/hilo_acc_file.sv | 118 +++++++++++
 tb/tb_hilo_acc_file.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
// Shared opcode encodings and default sizes for the HI/LO accumulator file.
package hilo_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_NUM_AC = 4;

    typedef enum logic [2:0] {
        OP_WR_BOTH = 3'b000,
        OP_WR_HI   = 3'b001,
        OP_WR_LO   = 3'b010,
        OP_CLR     = 3'b011,
        OP_MADD    = 3'b100,
        OP_MSUB    = 3'b101
    } op_e;

    // Codes 110 and 111 carry no operation and never commit.
    function automatic logic op_reserved(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/hilo_acc_alu.sv
// Combinational update unit: produces the new {hi,lo} of a pair from its base value.
module hilo_acc_alu
    import hilo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [2:0]          op,
    input  logic [2*DATA_W-1:0] base,
    input  logic [DATA_W-1:0]   hi,
    input  logic [DATA_W-1:0]   lo,
    output logic [2*DATA_W-1:0] res
);

    logic [2*DATA_W-1:0] operand;

    assign operand = {hi, lo};

    // Arithmetic is plain modulo 2^(2*DATA_W); carries and borrows simply wrap.
    always_comb begin
        res = base;
        case (op)
            OP_WR_BOTH: res = operand;
            OP_WR_HI:   res = {hi, base[DATA_W-1:0]};
            OP_WR_LO:   res = {base[2*DATA_W-1:DATA_W], lo};
            OP_CLR:     res = '0;
            OP_MADD:    res = base + operand;
            OP_MSUB:    res = base - operand;
            default:    res = base;
        endcase
    end

endmodule

// File: rtl/hilo_acc_file.sv
// File of NUM_AC HI/LO accumulator pairs updated through a two-stage pipeline
// (S1 capture, S2 result) with S2->S1 forwarding for back-to-back same-pair ops.
module hilo_acc_file
    import hilo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NUM_AC = DEF_NUM_AC,
    parameter int AC_W   = (NUM_AC > 1) ? $clog2(NUM_AC) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_i,
    input  logic [2:0]        op_i,
    input  logic [AC_W-1:0]   ac_i,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    input  logic [AC_W-1:0]   raddr_i,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              pending_o
);

    localparam int RES_W = 2 * DATA_W;

    logic [RES_W-1:0]  acc_reg [NUM_AC];
    logic [NUM_AC-1:0] pair_we;

    logic              s1_valid_reg;
    logic [2:0]        s1_op_reg;
    logic [AC_W-1:0]   s1_ac_reg;
    logic [DATA_W-1:0] s1_hi_reg;
    logic [DATA_W-1:0] s1_lo_reg;

    logic              s2_valid_reg;
    logic [AC_W-1:0]   s2_ac_reg;
    logic [RES_W-1:0]  s2_res_reg;

    logic              ac_in_range;
    logic              raddr_in_range;
    logic [RES_W-1:0]  base;
    logic [RES_W-1:0]  alu_res;
    logic [RES_W-1:0]  rd_data;

    // Indices past NUM_AC only exist when NUM_AC is not a power of two.
    assign ac_in_range    = {1'b0, ac_i}    < (AC_W + 1)'(NUM_AC);
    assign raddr_in_range = {1'b0, raddr_i} < (AC_W + 1)'(NUM_AC);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_reg <= 1'b0;
            s1_op_reg    <= '0;
            s1_ac_reg    <= '0;
            s1_hi_reg    <= '0;
            s1_lo_reg    <= '0;
        end else begin
            s1_valid_reg <= req_i && ac_in_range;
            s1_op_reg    <= op_i;
            s1_ac_reg    <= ac_i;
            s1_hi_reg    <= hi_i;
            s1_lo_reg    <= lo_i;
        end
    end

    // The op in S2 has not committed yet, so a same-pair op in S1 must see its result.
    assign base = (s2_valid_reg && (s2_ac_reg == s1_ac_reg)) ? s2_res_reg : acc_reg[s1_ac_reg];

    hilo_acc_alu #(
        .DATA_W(DATA_W)
    ) u_alu (
        .op  (s1_op_reg),
        .base(base),
        .hi  (s1_hi_reg),
        .lo  (s1_lo_reg),
        .res (alu_res)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid_reg <= 1'b0;
            s2_ac_reg    <= '0;
            s2_res_reg   <= '0;
        end else begin
            s2_valid_reg <= s1_valid_reg && !op_reserved(s1_op_reg);
            s2_ac_reg    <= s1_ac_reg;
            s2_res_reg   <= alu_res;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_AC; gi++) begin : g_pair_we
            assign pair_we[gi] = s2_valid_reg && (s2_ac_reg == AC_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_AC; i++) begin
                acc_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_AC; i++) begin
                if (pair_we[i]) begin
                    acc_reg[i] <= s2_res_reg;
                end
            end
        end
    end

    assign rd_data = raddr_in_range ? acc_reg[raddr_i] : '0;
    assign hi_o    = rd_data[RES_W-1:DATA_W];
    assign lo_o    = rd_data[DATA_W-1:0];

    // Reserved ops in S1 will never commit, so they do not hold off readers.
    assign pending_o = (s1_valid_reg && !op_reserved(s1_op_reg) && (s1_ac_reg == raddr_i)) ||
                       (s2_valid_reg && (s2_ac_reg == raddr_i));

endmodule

// File: tb/tb_hilo_acc_file.sv
// Bench for hilo_acc_file: directed vector table, asynchronous reset mid-operation,
// and random traffic checked against a sequential-execution reference model.
module tb_hilo_acc_file;

    localparam int DW  = 32;
    localparam int NAC = 4;
    localparam int AW  = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_i = 1'b0;
    logic [2:0]    op_i = '0;
    logic [AW-1:0] ac_i = '0;
    logic [DW-1:0] hi_i = '0;
    logic [DW-1:0] lo_i = '0;
    logic [AW-1:0] raddr_i = '0;
    logic [DW-1:0] hi_o;
    logic [DW-1:0] lo_o;
    logic          pending_o;

    int checks   = 0;
    int failures = 0;
    int edge_cnt = 0;

    hilo_acc_file #(
        .DATA_W(DW),
        .NUM_AC(NAC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_i    (req_i),
        .op_i     (op_i),
        .ac_i     (ac_i),
        .hi_i     (hi_i),
        .lo_i     (lo_i),
        .raddr_i  (raddr_i),
        .hi_o     (hi_o),
        .lo_o     (lo_o),
        .pending_o(pending_o)
    );

    always #5 clk = ~clk;

    // Reference model: ops retire in issue order two edges after issue.
    typedef struct {
        int            e;
        logic [2:0]    op;
        int            ac;
        logic [DW-1:0] hi;
        logic [DW-1:0] lo;
    } ent_t;

    ent_t          inflight[$];
    logic [2*DW-1:0] model [NAC];

    typedef struct {
        logic          req;
        logic [2:0]    op;
        logic [AW-1:0] ac;
        logic [DW-1:0] hi;
        logic [DW-1:0] lo;
        logic [AW-1:0] raddr;
        logic [DW-1:0] exp_hi;
        logic [DW-1:0] exp_lo;
        logic          exp_pend;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [2*DW-1:0] apply_op(input logic [2:0] op, input logic [2*DW-1:0] base,
                                                 input logic [DW-1:0] h, input logic [DW-1:0] l);
        case (op)
            3'd0:    return {h, l};
            3'd1:    return {h, base[DW-1:0]};
            3'd2:    return {base[2*DW-1:DW], l};
            3'd3:    return '0;
            3'd4:    return base + {h, l};
            3'd5:    return base - {h, l};
            default: return base;
        endcase
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic req, input logic [2:0] op, input logic [AW-1:0] ac,
                           input logic [DW-1:0] h, input logic [DW-1:0] l, input logic [AW-1:0] ra,
                           input logic [DW-1:0] eh, input logic [DW-1:0] el, input logic ep);
        vec_t v;
        v.req = req; v.op = op; v.ac = ac; v.hi = h; v.lo = l; v.raddr = ra;
        v.exp_hi = eh; v.exp_lo = el; v.exp_pend = ep;
        vecs.push_back(v);
    endtask

    // Called at a falling edge; returns at the next falling edge with the model updated.
    task automatic run_cycle(input logic req, input logic [2:0] op, input logic [AW-1:0] ac,
                             input logic [DW-1:0] h, input logic [DW-1:0] l, input logic [AW-1:0] ra);
        req_i = req; op_i = op; ac_i = ac; hi_i = h; lo_i = l; raddr_i = ra;
        @(posedge clk);
        edge_cnt++;
        if (req && op < 3'd6) begin
            ent_t x;
            x.e = edge_cnt; x.op = op; x.ac = int'(ac); x.hi = h; x.lo = l;
            inflight.push_back(x);
        end
        if (req) $display("txn e=%0d op=%0d ac=%0d hi=%h lo=%h", edge_cnt, op, ac, h, l);
        @(negedge clk);
        while (inflight.size() > 0 && edge_cnt >= inflight[0].e + 2) begin
            model[inflight[0].ac] = apply_op(inflight[0].op, model[inflight[0].ac], inflight[0].hi, inflight[0].lo);
            void'(inflight.pop_front());
        end
        req_i = 1'b0;
    endtask

    task automatic check_model(input string tag);
        logic exp_pend;
        exp_pend = 1'b0;
        foreach (inflight[i]) if (inflight[i].ac == int'(raddr_i)) exp_pend = 1'b1;
        check({tag, "_hi"}, hi_o, model[raddr_i][2*DW-1:DW]);
        check({tag, "_lo"}, lo_o, model[raddr_i][DW-1:0]);
        check({tag, "_pend"}, DW'(pending_o), DW'(exp_pend));
    endtask

    initial begin
        for (int i = 0; i < NAC; i++) model[i] = '0;

        //           req op    ac  hi            lo            ra  exp_hi        exp_lo        pend
        add_vec(1, 3'd0, 2, 32'h1,        32'h2,        2, 32'h0,        32'h0,        1);
        add_vec(0, 3'd0, 0, 32'h0,        32'h0,        2, 32'h0,        32'h0,        1);
        add_vec(0, 3'd0, 0, 32'h0,        32'h0,        2, 32'h1,        32'h2,        0);
        add_vec(1, 3'd0, 0, 32'h0,        32'hFFFFFFFF, 0, 32'h0,        32'h0,        1);
        add_vec(1, 3'd4, 0, 32'h0,        32'h1,        0, 32'h0,        32'h0,        1);
        add_vec(1, 3'd5, 0, 32'h1,        32'h1,        0, 32'h0,        32'hFFFFFFFF, 1);
        add_vec(0, 3'd0, 0, 32'h0,        32'h0,        0, 32'h1,        32'h0,        1);
        add_vec(0, 3'd0, 0, 32'h0,        32'h0,        0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        add_vec(1, 3'd4, 1, 32'h0,        32'h5,        1, 32'h0,        32'h0,        1);
        add_vec(1, 3'd4, 1, 32'h0,        32'h5,        1, 32'h0,        32'h0,        1);
        add_vec(1, 3'd4, 1, 32'h0,        32'h5,        1, 32'h0,        32'h5,        1);
        add_vec(0, 3'd0, 0, 32'h0,        32'h0,        1, 32'h0,        32'hA,        1);
        add_vec(0, 3'd0, 0, 32'h0,        32'h0,        1, 32'h0,        32'hF,        0);
        add_vec(1, 3'd0, 3, 32'hA,        32'hB,        3, 32'h0,        32'h0,        1);
        add_vec(1, 3'd1, 3, 32'hC,        32'h99,       3, 32'h0,        32'h0,        1);
        add_vec(1, 3'd2, 3, 32'h77,       32'hD,        3, 32'hA,        32'hB,        1);
        add_vec(1, 3'd3, 3, 32'h0,        32'h0,        3, 32'hC,        32'hB,        1);
        add_vec(0, 3'd0, 0, 32'h0,        32'h0,        3, 32'hC,        32'hD,        1);
        add_vec(0, 3'd0, 0, 32'h0,        32'h0,        3, 32'h0,        32'h0,        0);
        add_vec(1, 3'd4, 0, 32'h0,        32'h1,        0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
        add_vec(1, 3'd4, 1, 32'h0,        32'h3,        1, 32'h0,        32'hF,        1);
        add_vec(1, 3'd4, 0, 32'h0,        32'h1,        0, 32'h0,        32'h0,        1);
        add_vec(1, 3'd4, 1, 32'h0,        32'h3,        1, 32'h0,        32'h12,       1);
        add_vec(0, 3'd0, 0, 32'h0,        32'h0,        0, 32'h0,        32'h1,        0);
        add_vec(0, 3'd0, 0, 32'h0,        32'h0,        1, 32'h0,        32'h15,       0);
        add_vec(1, 3'd7, 2, 32'h5,        32'h5,        2, 32'h1,        32'h2,        0);
        add_vec(0, 3'd0, 0, 32'h0,        32'h0,        2, 32'h1,        32'h2,        0);
        add_vec(0, 3'd0, 0, 32'h0,        32'h0,        2, 32'h1,        32'h2,        0);

        // Reset state of every pair.
        repeat (2) @(negedge clk);
        for (int i = 0; i < NAC; i++) begin
            raddr_i = AW'(i);
            #1;
            check($sformatf("rst_hi%0d", i), hi_o, '0);
            check($sformatf("rst_lo%0d", i), lo_o, '0);
            check($sformatf("rst_pend%0d", i), DW'(pending_o), '0);
        end
        rst = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_cycle(vecs[i].req, vecs[i].op, vecs[i].ac, vecs[i].hi, vecs[i].lo, vecs[i].raddr);
            check($sformatf("vec%0d_hi", i), hi_o, vecs[i].exp_hi);
            check($sformatf("vec%0d_lo", i), lo_o, vecs[i].exp_lo);
            check($sformatf("vec%0d_pend", i), DW'(pending_o), DW'(vecs[i].exp_pend));
        end

        // Asynchronous reset while a WR_BOTH to pair 2 sits in S1.
        run_cycle(1, 3'd0, 2, 32'h55, 32'h66, 2);
        check("arst_pre_pend", DW'(pending_o), 32'h1);
        rst = 1'b0;
        #1;
        check("arst_hi", hi_o, '0);
        check("arst_lo", lo_o, '0);
        check("arst_pend", DW'(pending_o), '0);
        inflight.delete();
        for (int i = 0; i < NAC; i++) model[i] = '0;
        @(posedge clk);
        @(negedge clk);
        raddr_i = 1;
        #1;
        check("arst_pair1_lo", lo_o, '0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            run_cycle(0, 3'd0, 0, '0, '0, 2);
            check($sformatf("post_arst%0d_hi", i), hi_o, '0);
            check($sformatf("post_arst%0d_lo", i), lo_o, '0);
            check($sformatf("post_arst%0d_pend", i), DW'(pending_o), '0);
        end

        // Random traffic against the sequential model.
        for (int i = 0; i < 300; i++) begin
            logic [DW-1:0] rh;
            logic [DW-1:0] rl;
            rh = ($urandom_range(0, 1) == 0) ? DW'($urandom_range(0, 3)) : DW'($urandom);
            rl = ($urandom_range(0, 1) == 0) ? DW'($urandom_range(0, 7)) : DW'($urandom);
            run_cycle($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), AW'($urandom_range(0, NAC - 1)),
                      rh, rl, AW'($urandom_range(0, NAC - 1)));
            check_model($sformatf("rnd%0d", i));
        end
        for (int i = 0; i < 4; i++) begin
            run_cycle(0, 3'd0, 0, '0, '0, AW'(i));
            check_model($sformatf("drain%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
